calc1_req_seq: RTL and testbench
================================

// Module: calc1_req_seq
// PURPOSE
//  Upstream request sequencer for one calc1 port. Buffers whole operations (cmd, op1, op2)
//  in a small FIFO and drives them onto the port's req_cmd_in/req_data_in pins with the
//  two-cycle calc1 protocol. Waits for out_resp, then hands the response upstream via
//  valid/ready. One instance per port; the four instances feed calc1_top.
// PARAMETERS
//  DEPTH    4   operation FIFO entries (power of 2, >=2)
//  TIMEOUT  63  max c_clk cycles in WAIT before a timed-out response is generated (<=255)
// PORTS
//  c_clk         in   1   clock; all state updates on posedge
//  reset         in   1   asynchronous, active-high; clears all state
//  op_valid      in   1   upstream offers an operation
//  op_ready      out  1   FIFO not full; op accepted when op_valid & op_ready
//  op_cmd        in   4   calc1 command (0 nop, 1 add, 2 sub, 5 shl, 6 shr, others invalid)
//  op_data1      in   32  operand 1
//  op_data2      in   32  operand 2
//  req_cmd_out   out  4   to calc1 reqN_cmd_in
//  req_data_out  out  32  to calc1 reqN_data_in
//  port_resp     in   2   from calc1 out_respN (0 none, 1 ok, 2 over/underflow, 3 invalid)
//  port_data     in   32  from calc1 out_dataN
//  rsp_valid     out  1   response available
//  rsp_ready     in   1   upstream consumes response when rsp_valid & rsp_ready
//  rsp_resp      out  2   captured port_resp (0 when timed out)
//  rsp_data      out  32  captured port_data (0 when timed out)
//  rsp_cmd       out  4   command that produced this response
//  rsp_timeout   out  1   1 = response generated by timeout
//  proto_err     out  1   sticky: port_resp != 0 seen outside WAIT
// BEHAVIOUR
//  Reset: all outputs 0 except op_ready=1; FIFO empty; FSM IDLE; timeout counter 0.
//  FIFO: synchronous, registered outputs; op_ready = !full (no same-cycle bypass when full).
//  FSM (one op outstanding per port):
//   IDLE : FIFO non-empty -> pop, go ISSUE1. req_cmd_out=0, req_data_out=0.
//   ISSUE1: drive cmd=op_cmd, data=op_data1 for exactly 1 cycle -> ISSUE2.
//   ISSUE2: drive cmd=0, data=op_data2 for exactly 1 cycle -> WAIT, counter cleared.
//   WAIT : drive cmd=0, data=0. port_resp!=0 -> capture resp/data/cmd, rsp_timeout=0, -> DONE.
//          counter==TIMEOUT with no resp -> rsp_resp=0, rsp_data=0, rsp_timeout=1, -> DONE.
//          resp and timeout in same cycle: response wins (rsp_timeout=0).
//   DONE : rsp_valid=1, rsp_* held stable; on rsp_ready -> IDLE (rsp_valid drops next cycle).
//  Earliest cmd on pins: 2 cycles after an op accepted into empty FIFO (push, pop/IDLE->ISSUE1).
//  Back-to-back: after DONE handshake, next ISSUE1 no earlier than 2 cycles later (IDLE gap).
//  Cmd 0 (nop) is still issued; calc1 gives no response, so it completes by timeout.
//  proto_err: set when port_resp!=0 in IDLE/ISSUE1/ISSUE2/DONE; cleared only by reset.
//  Push while popping in same cycle: both honoured; count unchanged.
//  Reset mid-operation: outstanding and queued ops discarded, no response emitted; calc1 must
//  be reset in the same window (system requirement).
// STRUCTURE
//  Shared package calc1_pkg: cmd encodings (CMD_NOP/ADD/SUB/SHL/SHR), resp encodings
//  (RSP_NONE/OK/OVF/INV), FSM state enum {IDLE, ISSUE1, ISSUE2, WAIT, DONE}.
//  One sub-module: calc1_op_fifo (width 68, DEPTH entries, full/empty, push/pop).
//  FSM, counter and response registers in calc1_req_seq.
// TESTING
//  1 push add 0x0000_0003,0x0000_0004; calc1 model resp=1 data=7 after 3 cycles -> ISSUE1
//    cmd=1/data=3, ISSUE2 data=4, rsp_valid with rsp_resp=1, rsp_data=0x7, rsp_cmd=1.
//  2 push sub 0x1,0x2, model resp=2 -> rsp_resp=2, rsp_data per model, rsp_timeout=0.
//  3 push cmd 0 (nop), no resp -> after TIMEOUT cycles in WAIT rsp_timeout=1, rsp_resp=0.
//  4 push DEPTH+1 ops with rsp_ready=0 -> op_ready low once full; release rsp_ready ->
//    responses drained in push order, op_ready returns after first pop.
//  5 assert reset during WAIT -> all outputs reset values next edge, no rsp_valid after release.
//  6 model drives port_resp=1 during ISSUE2 -> proto_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared calc1 definitions: command/response encodings, sequencer states and the
// buffered operation layout.
package calc1_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RSP_NONE = 2'd0;
   localparam logic [1:0] RSP_OK   = 2'd1;
   localparam logic [1:0] RSP_OVF  = 2'd2;
   localparam logic [1:0] RSP_INV  = 2'd3;

   localparam int OP_W = 68;

   typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, WAIT, DONE} seq_state_t;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] data1;
      logic [31:0] data2;
   } op_t;

endpackage

// File: rtl/calc1_op_fifo.sv
// Operation FIFO: DEPTH entries, wrap-bit pointers, full/empty from pointer compare.
module calc1_op_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 68
) (
   input  logic             c_clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; only the pointers define which entries are valid.
   always_ff @(posedge c_clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/calc1_req_seq.sv
// Request sequencer for one calc1 port: buffers operations, issues them with the
// two-cycle protocol, waits for the response (or timeout) and offers it upstream.
module calc1_req_seq
   import calc1_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 63
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_cmd,
   input  logic [31:0] op_data1,
   input  logic [31:0] op_data2,
   output logic [3:0]  req_cmd_out,
   output logic [31:0] req_data_out,
   input  logic [1:0]  port_resp,
   input  logic [31:0] port_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_resp,
   output logic [31:0] rsp_data,
   output logic [3:0]  rsp_cmd,
   output logic        rsp_timeout,
   output logic        proto_err
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   seq_state_t  state_q, state_d;
   op_t         op_q, op_d, fifo_wr, fifo_rd;
   logic        fifo_full, fifo_empty, fifo_pop;
   logic [7:0]  cnt_q, cnt_d;
   logic [1:0]  rsp_resp_q, rsp_resp_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic [3:0]  rsp_cmd_q, rsp_cmd_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic        proto_err_q, proto_err_d;

   assign fifo_wr = {op_cmd, op_data1, op_data2};

   calc1_op_fifo #(.DEPTH(DEPTH), .WIDTH(OP_W)) u_fifo (
      .c_clk   (c_clk),
      .reset   (reset),
      .push    (op_valid),
      .pop     (fifo_pop),
      .wr_data (fifo_wr),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign op_ready    = !fifo_full;
   assign rsp_valid   = (state_q == DONE);
   assign rsp_resp    = rsp_resp_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_cmd     = rsp_cmd_q;
   assign rsp_timeout = rsp_timeout_q;
   assign proto_err   = proto_err_q;

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      cnt_d         = cnt_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_data_d    = rsp_data_q;
      rsp_cmd_d     = rsp_cmd_q;
      rsp_timeout_d = rsp_timeout_q;
      fifo_pop      = 1'b0;
      req_cmd_out   = '0;
      req_data_out  = '0;
      // Any response strobe outside WAIT means calc1 and this sequencer disagree.
      proto_err_d   = proto_err_q || ((port_resp != RSP_NONE) && (state_q != WAIT));
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_d     = fifo_rd;
               state_d  = ISSUE1;
            end
         end
         ISSUE1: begin
            req_cmd_out  = op_q.cmd;
            req_data_out = op_q.data1;
            state_d      = ISSUE2;
         end
         ISSUE2: begin
            req_data_out = op_q.data2;
            cnt_d        = '0;
            state_d      = WAIT;
         end
         WAIT: begin
            // A response arriving on the timeout cycle still counts as a real response.
            if (port_resp != RSP_NONE) begin
               rsp_resp_d    = port_resp;
               rsp_data_d    = port_data;
               rsp_cmd_d     = op_q.cmd;
               rsp_timeout_d = 1'b0;
               state_d       = DONE;
            end else if (cnt_q == TIMEOUT_C) begin
               rsp_resp_d    = RSP_NONE;
               rsp_data_d    = '0;
               rsp_cmd_d     = op_q.cmd;
               rsp_timeout_d = 1'b1;
               state_d       = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         op_q          <= '0;
         cnt_q         <= '0;
         rsp_resp_q    <= '0;
         rsp_data_q    <= '0;
         rsp_cmd_q     <= '0;
         rsp_timeout_q <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         cnt_q         <= cnt_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_data_q    <= rsp_data_d;
         rsp_cmd_q     <= rsp_cmd_d;
         rsp_timeout_q <= rsp_timeout_d;
         proto_err_q   <= proto_err_d;
      end
   end

endmodule

// File: tb/tb_calc1_req_seq.sv
// Bench for calc1_req_seq: calc1 port model plus a response scoreboard.
module tb_calc1_req_seq;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 63;

   logic        c_clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_cmd;
   logic [31:0] op_data1, op_data2;
   logic [3:0]  req_cmd_out;
   logic [31:0] req_data_out;
   logic [1:0]  m_resp, inj_resp;
   logic [31:0] m_data;
   logic        rsp_valid, rsp_ready;
   logic [1:0]  rsp_resp;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_cmd;
   logic        rsp_timeout;
   logic        proto_err;

   logic        model_en;
   int          model_delay;
   int          n_checks = 0;
   int          n_pass   = 0;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      logic [3:0]  cmd;
      logic        timeout;
   } exp_t;

   exp_t sb[$];

   calc1_req_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_cmd       (op_cmd),
      .op_data1     (op_data1),
      .op_data2     (op_data2),
      .req_cmd_out  (req_cmd_out),
      .req_data_out (req_data_out),
      .port_resp    (m_resp | inj_resp),
      .port_data    (m_data),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_resp     (rsp_resp),
      .rsp_data     (rsp_data),
      .rsp_cmd      (rsp_cmd),
      .rsp_timeout  (rsp_timeout),
      .proto_err    (proto_err)
   );

   always #5 c_clk = ~c_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Behaviour of a calc1 port as seen from the sequencer; nop never answers.
   function automatic exp_t calc1_ref(input logic [3:0] cmd, input logic [31:0] d1,
                                      input logic [31:0] d2);
      exp_t        e;
      logic [32:0] s;
      e.cmd     = cmd;
      e.timeout = 1'b0;
      e.resp    = 2'd1;
      e.data    = '0;
      case (cmd)
         4'd0: begin e.resp = 2'd0; e.timeout = 1'b1; end
         4'd1: begin
            s      = {1'b0, d1} + {1'b0, d2};
            e.data = s[31:0];
            e.resp = s[32] ? 2'd2 : 2'd1;
         end
         4'd2: begin e.data = d1 - d2; e.resp = (d2 > d1) ? 2'd2 : 2'd1; end
         4'd5: e.data = d1 << d2[4:0];
         4'd6: e.data = d1 >> d2[4:0];
         default: e.resp = 2'd3;
      endcase
      return e;
   endfunction

   // calc1 port model: latch the two request cycles, answer model_delay cycles later.
   initial begin
      logic [3:0]  c;
      logic [31:0] a, b;
      exp_t        r;
      m_resp = '0;
      m_data = '0;
      forever begin
         @(posedge c_clk); #1;
         if (model_en && !reset && req_cmd_out != 4'd0) begin
            c = req_cmd_out;
            a = req_data_out;
            @(posedge c_clk); #1;
            b = req_data_out;
            r = calc1_ref(c, a, b);
            repeat (model_delay) @(posedge c_clk);
            #1;
            m_resp = r.resp;
            m_data = r.data;
            @(posedge c_clk); #1;
            m_resp = '0;
            m_data = '0;
         end
      end
   end

   // Response monitor: one comparison set per completed handshake.
   always @(negedge c_clk) begin
      exp_t e;
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            check("rsp_resp",    64'(rsp_resp),    64'(e.resp));
            check("rsp_data",    64'(rsp_data),    64'(e.data));
            check("rsp_cmd",     64'(rsp_cmd),     64'(e.cmd));
            check("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
         end
      end
   end

   task automatic push_op(input logic [3:0] cmd, input logic [31:0] d1, input logic [31:0] d2);
      int n = 0;
      op_cmd   = cmd;
      op_data1 = d1;
      op_data2 = d2;
      op_valid = 1'b1;
      while (!op_ready && n < 300) begin
         @(posedge c_clk); #1;
         n++;
      end
      check("push_ready", 64'(op_ready), 64'd1);
      @(posedge c_clk); #1;
      op_valid = 1'b0;
      sb.push_back(calc1_ref(cmd, d1, d2));
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge c_clk); #1;
         n++;
      end
      check({"drain_", tag}, 64'(sb.size()), 64'd0);
      repeat (3) @(posedge c_clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int seen;
      reset       = 1'b1;
      op_valid    = 1'b0;
      op_cmd      = '0;
      op_data1    = '0;
      op_data2    = '0;
      rsp_ready   = 1'b1;
      inj_resp    = '0;
      model_en    = 1'b1;
      model_delay = 3;
      repeat (3) @(posedge c_clk);
      #1;
      check("rst_op_ready",  64'(op_ready),     64'd1);
      check("rst_rsp_valid", 64'(rsp_valid),    64'd0);
      check("rst_req_cmd",   64'(req_cmd_out),  64'd0);
      check("rst_req_data",  64'(req_data_out), 64'd0);
      check("rst_proto_err", 64'(proto_err),    64'd0);
      reset = 1'b0;
      repeat (2) @(posedge c_clk);
      #1;

      // 1: add, plus the exact request pin sequence
      push_op(4'd1, 32'h3, 32'h4);
      n = 0;
      do begin
         @(negedge c_clk);
         n++;
      end while (req_cmd_out == 4'd0 && n < 20);
      check("issue1_cmd",  64'(req_cmd_out),  64'd1);
      check("issue1_data", 64'(req_data_out), 64'h3);
      @(negedge c_clk);
      check("issue2_cmd",  64'(req_cmd_out),  64'd0);
      check("issue2_data", 64'(req_data_out), 64'h4);
      @(negedge c_clk);
      check("wait_data",   64'(req_data_out), 64'd0);
      wait_drain("add");

      // 2: sub underflow
      push_op(4'd2, 32'h1, 32'h2);
      wait_drain("sub");

      // 3: nop completes by timeout
      push_op(4'd0, 32'h5, 32'h6);
      wait_drain("nop");

      // other encodings, back to back
      push_op(4'd5, 32'h0000_0003, 32'd4);
      push_op(4'd6, 32'h8000_0000, 32'd31);
      push_op(4'd7, 32'h1, 32'h1);
      push_op(4'd1, 32'hFFFF_FFFF, 32'h2);
      wait_drain("mix");

      // 4: fill the FIFO while the response is held
      rsp_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) push_op(4'd1, 32'(i), 32'd100);
      check("full_op_ready", 64'(op_ready), 64'd0);
      repeat (10) @(posedge c_clk);
      #1;
      check("full_hold", 64'(op_ready), 64'd0);
      rsp_ready = 1'b1;
      n = 0;
      while (!op_ready && n < 20) begin
         @(posedge c_clk); #1;
         n++;
      end
      check("ready_return", 64'(op_ready), 64'd1);
      wait_drain("fill");

      // 5: reset during WAIT discards the outstanding and queued operations
      push_op(4'd0, 32'h5, 32'h6);
      push_op(4'd1, 32'h1, 32'h1);
      n = 0;
      do begin
         @(negedge c_clk);
         n++;
      end while (!(req_cmd_out == 4'd0 && req_data_out == 32'h6) && n < 50);
      check("reach_issue2", 64'(req_data_out), 64'h6);
      repeat (5) @(posedge c_clk);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_valid",   64'(rsp_valid),   64'd0);
      check("mid_rst_ready",   64'(op_ready),    64'd1);
      check("mid_rst_timeout", 64'(rsp_timeout), 64'd0);
      check("mid_rst_cmd",     64'(req_cmd_out), 64'd0);
      sb.delete();
      @(posedge c_clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < TIMEOUT + 40; i++) begin
         @(negedge c_clk);
         if (rsp_valid) seen++;
      end
      check("post_rst_no_rsp", 64'(seen), 64'd0);

      // 6: response strobe during ISSUE2 is a protocol error
      model_en = 1'b0;
      check("proto_before", 64'(proto_err), 64'd0);
      push_op(4'd0, 32'h11, 32'h22);
      n = 0;
      do begin
         @(negedge c_clk);
         n++;
      end while (!(req_cmd_out == 4'd0 && req_data_out == 32'h22) && n < 50);
      inj_resp = 2'd1;
      @(posedge c_clk); #1;
      inj_resp = 2'd0;
      check("proto_set", 64'(proto_err), 64'd1);
      wait_drain("proto");
      check("proto_sticky", 64'(proto_err), 64'd1);
      reset = 1'b1;
      #1;
      check("proto_clear", 64'(proto_err), 64'd0);
      @(posedge c_clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge c_clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
